// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and bit reversal.
package shifter_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_op_e;

   localparam int unsigned MaxWidth = 64;

   // Reverses the low i_width bits into the low i_width bits; upper bits return zero.
   function automatic logic [MaxWidth-1:0] bit_reverse(input logic [MaxWidth-1:0] i_data,
                                                       input int unsigned          i_width);
      logic [MaxWidth-1:0] v_rev;
      v_rev = '0;
      for (int i = 0; i < int'(MaxWidth); i++) begin
         if (i < int'(i_width)) v_rev[i] = i_data[int'(i_width) - 1 - i];
      end
      return v_rev;
   endfunction

endpackage

// File: rtl/shifter_stage.sv
// One log2 stage of the barrel shifter: a fixed-distance right shift with per-mode fill.
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIST  = 1
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_enable,
   input  logic [1:0]       i_op,
   input  logic             i_sign,
   output logic [WIDTH-1:0] o_data
);

   // Left shifts arrive bit-reversed, so every mode is a right shift here.
   always_comb begin
      o_data = i_data;
      if (i_enable) begin
         unique case (i_op)
            SHIFT_SLL, SHIFT_SRL: o_data = i_data >> DIST;
            SHIFT_SRA:            o_data = {{DIST{i_sign}}, i_data[WIDTH-1:DIST]};
            SHIFT_ROR:            o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
            default:              o_data = i_data;
         endcase
      end
   end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR), one register per log2 stage,
// valid/ready flow control with bubble collapsing, tag passthrough and flush.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH),
   parameter int unsigned TAG_W   = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [WIDTH-1:0]   i_in_data,
   input  logic [SHAMT_W-1:0] i_in_shamt,
   input  logic [1:0]         i_in_op,
   input  logic [TAG_W-1:0]   i_in_tag,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [WIDTH-1:0]   o_out_data,
   output logic [TAG_W-1:0]   o_out_tag
);

   logic [WIDTH-1:0]   r_data  [SHAMT_W];
   logic [SHAMT_W-1:0] r_shamt [SHAMT_W];
   logic [1:0]         r_op    [SHAMT_W];
   logic [TAG_W-1:0]   r_tag   [SHAMT_W];
   logic [SHAMT_W-1:0] r_sign;
   logic [SHAMT_W-1:0] r_valid;

   logic [WIDTH-1:0]   w_src_data  [SHAMT_W];
   logic [SHAMT_W-1:0] w_src_shamt [SHAMT_W];
   logic [1:0]         w_src_op    [SHAMT_W];
   logic [TAG_W-1:0]   w_src_tag   [SHAMT_W];
   logic [SHAMT_W-1:0] w_src_sign;
   logic [SHAMT_W-1:0] w_src_valid;
   logic [WIDTH-1:0]   w_stage_out [SHAMT_W];
   logic [WIDTH-1:0]   w_cap_data  [SHAMT_W];
   logic [SHAMT_W-1:0] w_en;
   logic               w_in_fire;

   // A stage may capture if it or any stage downstream of it has room this cycle.
   always_comb begin : p_advance
      logic v_room;
      w_en   = '0;
      v_room = i_out_ready;
      for (int k = int'(SHAMT_W) - 1; k >= 0; k--) begin
         v_room  = v_room || !r_valid[k];
         w_en[k] = v_room;
      end
   end

   assign o_in_ready = i_rst_n && !i_flush && w_en[0];
   assign w_in_fire  = i_in_valid && o_in_ready;

   always_comb begin : p_source
      w_src_valid[0] = w_in_fire;
      w_src_data[0]  = (i_in_op == SHIFT_SLL) ?
                       WIDTH'(bit_reverse(MaxWidth'(i_in_data), WIDTH)) : i_in_data;
      w_src_shamt[0] = i_in_shamt;
      w_src_op[0]    = i_in_op;
      w_src_sign[0]  = i_in_data[WIDTH-1];
      w_src_tag[0]   = i_in_tag;
      for (int k = 1; k < int'(SHAMT_W); k++) begin
         w_src_valid[k] = r_valid[k-1];
         w_src_data[k]  = r_data[k-1];
         w_src_shamt[k] = r_shamt[k-1];
         w_src_op[k]    = r_op[k-1];
         w_src_sign[k]  = r_sign[k-1];
         w_src_tag[k]   = r_tag[k-1];
      end
   end

   for (genvar k = 0; k < int'(SHAMT_W); k++) begin : g_stage
      shifter_stage #(
         .WIDTH (WIDTH),
         .DIST  (2 ** k)
      ) u_stage (
         .i_data   (w_src_data[k]),
         .i_enable (w_src_shamt[k][k]),
         .i_op     (w_src_op[k]),
         .i_sign   (w_src_sign[k]),
         .o_data   (w_stage_out[k])
      );
   end

   // Undo the entry reversal before the last register so outputs come straight from flops.
   always_comb begin : p_capture
      for (int k = 0; k < int'(SHAMT_W) - 1; k++) w_cap_data[k] = w_stage_out[k];
      w_cap_data[SHAMT_W-1] = (w_src_op[SHAMT_W-1] == SHIFT_SLL) ?
         WIDTH'(bit_reverse(MaxWidth'(w_stage_out[SHAMT_W-1]), WIDTH)) :
         w_stage_out[SHAMT_W-1];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         r_sign  <= '0;
         for (int k = 0; k < int'(SHAMT_W); k++) begin
            r_data[k]  <= '0;
            r_shamt[k] <= '0;
            r_op[k]    <= '0;
            r_tag[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < int'(SHAMT_W); k++) begin
            if (i_flush) begin
               r_valid[k] <= 1'b0;
            end else if (w_en[k]) begin
               r_valid[k] <= w_src_valid[k];
            end
            if (w_en[k]) begin
               r_data[k]  <= w_cap_data[k];
               r_shamt[k] <= w_src_shamt[k];
               r_op[k]    <= w_src_op[k];
               r_sign[k]  <= w_src_sign[k];
               r_tag[k]   <= w_src_tag[k];
            end
         end
      end
   end

   assign o_out_valid = r_valid[SHAMT_W-1];
   assign o_out_data  = r_data[SHAMT_W-1];
   assign o_out_tag   = r_tag[SHAMT_W-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter at WIDTH=32: directed vectors, latency,
// back-to-back, backpressure, flush and asynchronous reset.
module tb_pipelined_shifter;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned SW    = 5;
   localparam int unsigned TW    = 5;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   logic             i_clk, i_rst_n, i_flush, i_in_valid, i_out_ready;
   logic             o_in_ready, o_out_valid;
   logic [WIDTH-1:0] i_in_data, o_out_data;
   logic [SW-1:0]    i_in_shamt;
   logic [1:0]       i_in_op;
   logic [TW-1:0]    i_in_tag, o_out_tag;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [TW-1:0]    tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   pipelined_shifter #(
      .WIDTH (WIDTH),
      .TAG_W (TW)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_flush),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_data   (i_in_data),
      .i_in_shamt  (i_in_shamt),
      .i_in_op     (i_in_op),
      .i_in_tag    (i_in_tag),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_out_data  (o_out_data),
      .o_out_tag   (o_out_tag)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every output transfer must match the head of the scoreboard.
   always @(negedge i_clk) begin
      if (i_rst_n && o_out_valid && i_out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 64'(o_out_tag), 64'h1f_ffff);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", 64'(o_out_data), 64'(e.data));
            check("out_tag", 64'(o_out_tag), 64'(e.tag));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                       input logic [4:0] t, input logic [31:0] exp);
      bit   done;
      exp_t e;
      done       = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = d;
      i_in_shamt = s;
      i_in_op    = op;
      i_in_tag   = t;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge i_clk);
         if (o_in_ready) begin
            e.data = exp;
            e.tag  = t;
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge i_clk);
         #1;
      end
      i_in_valid = 1'b0;
      if (!done) check("send_timeout", 64'd0, 64'd1);
   endtask

   // Out_valid must be low for four negedges after a transfer and high on the fifth.
   task automatic check_latency(input string name);
      for (int i = 1; i <= 5; i++) begin
         @(negedge i_clk);
         check(name, 64'(o_out_valid), (i == 5) ? 64'd1 : 64'd0);
      end
   endtask

   logic [31:0] v_data [10] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_000F,
                                32'h7FFF_FFFF, 32'h1234_5678, 32'h1234_5678, 32'h8765_4321,
                                32'h8765_4321, 32'h0000_0001};
   logic [4:0]  v_sh   [10] = '{5'd31, 5'd4, 5'd31, 5'd4, 5'd4, 5'd8, 5'd8, 5'd8, 5'd8, 5'd31};
   logic [1:0]  v_op   [10] = '{OP_SRA, OP_SRL, OP_SLL, OP_ROR, OP_SRA, OP_SLL, OP_ROR, OP_SRA,
                                OP_SRL, OP_ROR};
   logic [4:0]  v_tag  [10] = '{5'd7, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10};
   logic [31:0] v_exp  [10] = '{32'hFFFF_FFFF, 32'h0800_0000, 32'h8000_0000, 32'hF000_0000,
                                32'h07FF_FFFF, 32'h3456_7800, 32'h7812_3456, 32'hFF87_6543,
                                32'h0087_6543, 32'h0000_0002};
   logic [31:0] bp_exp [5]  = '{32'h8000_0000, 32'hC000_0000, 32'hE000_0000, 32'hF000_0000,
                                32'hF800_0000};

   initial begin
      int first, last, cnt, idx;
      logic [31:0] held;
      i_rst_n = 1'b0;  i_flush = 1'b0;  i_in_valid = 1'b0;  i_out_ready = 1'b1;
      i_in_data = '0;  i_in_shamt = '0; i_in_op = '0;       i_in_tag = '0;

      #22;
      check("reset_out_valid", 64'(o_out_valid), 64'd0);
      check("reset_in_ready", 64'(o_in_ready), 64'd0);
      check("reset_out_data", 64'(o_out_data), 64'd0);
      check("reset_out_tag", 64'(o_out_tag), 64'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      check("in_ready_after_reset", 64'(o_in_ready), 64'd1);

      // First vector alone to measure latency, then the rest of the directed table.
      send(v_data[0], v_sh[0], v_op[0], v_tag[0], v_exp[0]);
      check_latency("latency_sra");
      @(posedge i_clk); #1;
      for (int i = 1; i < 10; i++) send(v_data[i], v_sh[i], v_op[i], v_tag[i], v_exp[i]);
      repeat (8) @(posedge i_clk);
      #1;
      check("drain_directed", 64'(sb.size()), 64'd0);

      // Back-to-back: tags 0..7 on consecutive cycles.
      first = -1; last = -1; cnt = 0;
      fork
         for (int i = 0; i < 8; i++)
            send(32'h1, 5'(i), OP_SLL, 5'(i), 32'h1 << i);
         for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_out_valid) begin
               if (first < 0) first = c;
               last = c;
               cnt++;
            end
         end
      join
      check("b2b_count", 64'(cnt), 64'd8);
      check("b2b_consecutive", 64'(last - first), 64'd7);

      // Backpressure: 10 cycles of offered input with the consumer stalled.
      @(posedge i_clk); #1;
      i_out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         i_in_valid = 1'b1;
         i_in_data  = 32'h8000_0000;
         i_in_shamt = 5'(idx);
         i_in_op    = OP_SRA;
         i_in_tag   = 5'(16 + idx);
         @(negedge i_clk);
         if (o_in_ready) begin
            exp_t e;
            e.data = (idx < 5) ? bp_exp[idx] : 32'h0;
            e.tag  = 5'(16 + idx);
            sb.push_back(e);
            idx++;
         end
         @(posedge i_clk); #1;
      end
      i_in_valid = 1'b0;
      check("bp_accepted", 64'(idx), 64'd5);
      @(negedge i_clk);
      check("bp_in_ready_low", 64'(o_in_ready), 64'd0);
      check("bp_out_valid", 64'(o_out_valid), 64'd1);
      held = o_out_data;
      repeat (3) @(negedge i_clk);
      check("bp_data_stable", 64'(o_out_data), 64'(held));
      check("bp_head_data", 64'(o_out_data), 64'h8000_0000);
      @(posedge i_clk); #1;
      i_out_ready = 1'b1;
      repeat (8) @(posedge i_clk);
      #1;
      check("bp_drained", 64'(sb.size()), 64'd0);

      // Flush with three entries in flight and a coincident input.
      for (int i = 0; i < 3; i++) send(32'hA5A5_0000, 5'd1, OP_SRL, 5'(20 + i), 32'h52D2_8000);
      i_in_valid = 1'b1;
      i_flush    = 1'b1;
      i_in_tag   = 5'd30;
      @(negedge i_clk);
      check("flush_in_ready_low", 64'(o_in_ready), 64'd0);
      @(posedge i_clk); #1;
      i_flush    = 1'b0;
      i_in_valid = 1'b0;
      sb.delete();
      @(negedge i_clk);
      check("flush_in_ready_back", 64'(o_in_ready), 64'd1);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (o_out_valid) cnt++;
         @(negedge i_clk);
      end
      check("flush_no_results", 64'(cnt), 64'd0);

      // Asynchronous reset with a stalled result at the output.
      @(posedge i_clk); #1;
      i_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(32'hFFFF_0000, 5'd4, OP_SRL, 5'(i), 32'h0FFF_F000);
      @(negedge i_clk);
      check("pre_reset_out_valid", 64'(o_out_valid), 64'd1);
      @(posedge i_clk); #3;
      i_rst_n = 1'b0;
      #1;
      check("async_reset_out_valid", 64'(o_out_valid), 64'd0);
      check("async_reset_in_ready", 64'(o_in_ready), 64'd0);
      check("async_reset_out_data", 64'(o_out_data), 64'd0);
      sb.delete();
      i_out_ready = 1'b1;
      @(negedge i_clk); #2;
      i_rst_n = 1'b1;
      #1;
      check("in_ready_after_async", 64'(o_in_ready), 64'd1);
      @(posedge i_clk); #1;
      send(32'h0000_00F0, 5'd4, OP_SRL, 5'd11, 32'h0000_000F);
      check_latency("latency_after_reset");

      // shamt = 0 passes data through for every op.
      @(posedge i_clk); #1;
      for (int op = 0; op < 4; op++) send(32'hDEAD_BEEF, 5'd0, 2'(op), 5'(24 + op), 32'hDEAD_BEEF);

      for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge i_clk);
      #1;
      check("final_drain", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter. Supports logical left, logical right, arithmetic right and rotate right.
- Successor to the 32-bit combinational arithmetic right shifter. Generalised in width, with mode select, one register per log2 shift stage, valid/ready flow control, a tag passthrough and a flush.
- Sits between the ALU operand muxes and writeback. The tag carries the destination register index.

Parameters:
- WIDTH, 32, data width. Power of two, 8 to 64.
- SHAMT_W, $clog2(WIDTH), shift-amount width and number of shift stages. Derived; never overridden.
- TAG_W, 5, width of the sideband tag carried alongside the data.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; clears all in-flight entries
- in_valid  in  1  input operation present
- in_ready  out  1  block accepts input this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift amount
- in_op  in  2  mode select: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Stages
  - Stage k (k = 0..SHAMT_W-1) shifts by 2^k when shamt bit k is set.
  - Each stage is followed by a register holding data, remaining shamt, op, tag, a sign bit and a valid bit.
  - Latency: SHAMT_W cycles from input handshake to out_valid (5 at WIDTH=32) with no backpressure.
  - Throughput: one operation per cycle.
- Sign bit
  - Captured from in_data[WIDTH-1] at entry.
  - Used as the SRA fill at every stage, so the fill is always the original operand's MSB.
- Left shift
  - SLL reverses bits at entry, shifts right with zero fill, and reverses again at exit.
  - Equivalently, a left path per stage. The result must be identical either way.
- Fill per mode
  - SRL: 0.
  - SRA: sign bit.
  - ROR: the bits shifted out of the low end wrap into the high end.
  - SLL: 0 enters at the LSB.
- Shift amount
  - shamt = 0 passes the data through unchanged for every op.
  - shamt = WIDTH-1 is the maximum. Amounts of WIDTH or more are not representable.
- Handshake
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - The pipeline advances per stage. Stage k captures when it is empty or when stage k+1 captures or drains that cycle (bubble-collapsing).
  - in_ready = !valid[0] || stage 1 can capture. It is combinational from out_ready through the chain.
  - While out_valid && !out_ready, out_data and out_tag hold stable. Upstream stages fill any bubbles, then stall.
  - in_data, in_shamt, in_op and in_tag are sampled only on an input transfer.
- Flush
  - Next edge clears every valid bit. Data registers are don't-care.
  - in_ready is held 0 during the flush cycle; an input presented that cycle is dropped.
  - Flush has priority over a simultaneous output transfer. That result is considered consumed; out_valid is 0 the next cycle.
- Reset
  - reset_n low asynchronously clears all valid bits.
  - While reset_n is low: out_valid=0, out_data=0, out_tag=0, in_ready=0.
  - in_ready rises the first cycle after reset_n deasserts.
  - Reset mid-operation discards all in-flight entries; no partial result is emitted.
- Outputs are driven directly from the last stage register, with no combinational path from in_* to out_*.

Decomposition:
- Shared package shifter_pkg:
  - op encodings SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROR=2'b11;
  - helper function for bit reversal.
- Sub-module shifter_stage (parameters WIDTH and DIST):
  - combinational single-distance shift;
  - inputs data, enable, op, sign;
  - output shifted data;
  - instantiated SHAMT_W times with DIST = 1, 2, 4, ...

Test Plan:
- WIDTH=32: SRA, data 0x80000000, shamt 31, tag 7 -> after 5 cycles out_data 0xFFFFFFFF, out_tag 7.
- SRL 0x80000000 >> 4 -> 0x08000000. SLL 0x00000001 << 31 -> 0x80000000. ROR 0x0000000F by 4 -> 0xF0000000.
- Back-to-back: 8 consecutive ops with out_ready=1 -> 8 results on consecutive cycles, in order. Tags 0..7 are preserved.
- Backpressure: out_ready=0 for 10 cycles with a continuous input stream -> exactly 5 entries accepted, then in_ready=0. out_data stays stable. Releasing out_ready drains in order with no loss or duplication.
- Flush with 3 entries in flight, coincident with in_valid=1 -> no results emerge, the coincident input is dropped, and in_ready=1 the next cycle.
- reset_n pulsed low asynchronously mid-stream -> out_valid=0 immediately. The first op after release emerges 5 cycles after its transfer. shamt=0 returns the input unchanged for all four ops.
